// File: rtl/fir_pkg.sv
// Shared constants, width helpers and FSM encoding for the TDM FIR family.
package fir_pkg;

  localparam int DEF_BIT_PREC = 8;
  localparam int DEF_COEF_W   = 8;
  localparam int DEF_N_TAPS   = 8;
  localparam int DEF_N_CH     = 2;

  // Tap index width; the filter always has at least two taps.
  function automatic int tap_w(input int n_taps);
    return (n_taps > 1) ? $clog2(n_taps) : 1;
  endfunction

  // Channel tag width; a single-channel build still carries a 1-bit tag.
  function automatic int ch_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fir_state_t;

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate with synchronous clear and enable.
module fir_mac #(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int ACC_W = 19
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [A_W-1:0]   a_i,
  input  logic signed [B_W-1:0]   b_i,
  output logic signed [ACC_W-1:0] acc_o
);

  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0]   a_ext;
  logic signed [P_W-1:0]   b_ext;
  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  // Operands are widened to the full product width so the multiply is exact.
  assign a_ext    = {{B_W{a_i[A_W-1]}}, a_i};
  assign b_ext    = {{A_W{b_i[B_W-1]}}, b_i};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};

  // Clear wins over enable; otherwise hold.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod_ext;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_tdm.sv
// Time-multiplexed multi-channel FIR: one shared MAC, per-channel delay lines,
// runtime-loadable coefficients shared by all channels.
//
//   state | meaning
//   IDLE  | waiting for a sample; coefficient writes allowed
//   MAC   | one tap per enabled cycle into the shared accumulator
//   DONE  | publish accumulator as a one-cycle result pulse
module fir_tdm
  import fir_pkg::*;
#(
  parameter  int BIT_PREC = DEF_BIT_PREC,
  parameter  int COEF_W   = DEF_COEF_W,
  parameter  int N_TAPS   = DEF_N_TAPS,
  parameter  int N_CH     = DEF_N_CH,
  localparam int TAP_W    = tap_w(N_TAPS),
  localparam int CH_W     = ch_w(N_CH),
  localparam int OUT_SIZE = BIT_PREC + COEF_W + TAP_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fir_en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CH_W-1:0]            in_ch,
  input  logic signed [BIT_PREC-1:0] in_wave,
  input  logic                       coef_we,
  input  logic [TAP_W-1:0]           coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  output logic                       coef_ready,
  output logic                       out_valid,
  output logic [CH_W-1:0]            out_ch,
  output logic signed [OUT_SIZE-1:0] out_wave
);

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(N_TAPS - 1);

  fir_state_t state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             out_valid_q, out_valid_d;
  logic [CH_W-1:0]  out_ch_q;
  logic signed [OUT_SIZE-1:0] out_wave_q;

  logic signed [BIT_PREC-1:0] x_q [N_CH][N_TAPS];
  logic signed [COEF_W-1:0]   c_q [N_TAPS];

  logic signed [BIT_PREC-1:0] mac_x;
  logic signed [COEF_W-1:0]   mac_c;
  logic signed [OUT_SIZE-1:0] acc;

  logic ch_ok, addr_ok, idle_en, sample_take, coef_take, mac_en;

  // Range checks collapse to constants when the index width is fully used.
  if (N_CH == (1 << CH_W)) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);
    assign ch_ok = ({1'b0, in_ch} < N_CH_L);
  end

  if (N_TAPS == (1 << TAP_W)) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_part
    localparam logic [TAP_W:0] N_TAPS_L = (TAP_W + 1)'(N_TAPS);
    assign addr_ok = ({1'b0, coef_addr} < N_TAPS_L);
  end

  assign idle_en     = fir_en && (state_q == IDLE);
  assign in_ready    = idle_en;
  assign coef_ready  = idle_en;
  // Out-of-range channels are consumed by the handshake but never processed.
  assign sample_take = in_valid && idle_en && ch_ok;
  assign coef_take   = coef_we && idle_en && addr_ok;
  assign mac_en      = fir_en && (state_q == MAC);

  // Next-state logic: every transition out of MAC/DONE waits for fir_en.
  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    ch_d        = ch_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_take) begin
          state_d = MAC;
          tap_d   = '0;
          ch_d    = in_ch;
        end
      end
      MAC: begin
        if (fir_en) begin
          tap_d = tap_q + TAP_W'(1);
          if (tap_q == LAST_TAP) state_d = DONE;
        end
      end
      DONE: begin
        if (fir_en) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers; results only change on a completed DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      ch_q        <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_wave_q  <= '0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      ch_q        <= ch_d;
      out_valid_q <= out_valid_d;
      if (out_valid_d) begin
        out_ch_q   <= ch_q;
        out_wave_q <= acc;
      end
    end
  end

  // Per-channel delay lines; only the addressed channel shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int t = 0; t < N_TAPS; t++) x_q[c][t] <= '0;
      end
    end else if (sample_take) begin
      for (int c = 0; c < N_CH; c++) begin
        if (in_ch == CH_W'(c)) begin
          for (int t = N_TAPS - 1; t > 0; t--) x_q[c][t] <= x_q[c][t-1];
          x_q[c][0] <= in_wave;
        end
      end
    end
  end

  // Coefficient register file; resets to an identity (pass-through) filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < N_TAPS; t++) c_q[t] <= (t == 0) ? COEF_W'(1) : '0;
    end else if (coef_take) begin
      for (int t = 0; t < N_TAPS; t++) begin
        if (coef_addr == TAP_W'(t)) c_q[t] <= coef_data;
      end
    end
  end

  // Operand select for the current tap of the latched channel.
  always_comb begin
    mac_x = '0;
    mac_c = '0;
    for (int t = 0; t < N_TAPS; t++) begin
      if (tap_q == TAP_W'(t)) begin
        mac_c = c_q[t];
        for (int c = 0; c < N_CH; c++) begin
          if (ch_q == CH_W'(c)) mac_x = x_q[c][t];
        end
      end
    end
  end

  fir_mac #(
    .A_W  (BIT_PREC),
    .B_W  (COEF_W),
    .ACC_W(OUT_SIZE)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(sample_take),
    .en_i (mac_en),
    .a_i  (mac_x),
    .b_i  (mac_c),
    .acc_o(acc)
  );

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_wave  = out_wave_q;

endmodule

// File: doc/fir_tdm.md
Name: fir_tdm

Overview:
Parametrised, time-multiplexed FIR filter. It is the successor of fir.
- Single shared signed MAC iterates N_TAPS cycles per accepted sample.
- Serves N_CH independent channels, each with its own delay line.
- Coefficients are runtime-loadable and shared by all channels.
- Input uses a valid/ready handshake. Output is a one-cycle valid pulse tagged with its channel.
- Sits between the sample source (fir_driver-style stimulus or ADC front end) and downstream consumers.

Parameters:
- BIT_PREC, 8: signed input sample width.
- COEF_W, 8: signed coefficient width.
- N_TAPS, 8: filter length, ≥2.
- N_CH, 2: number of channels, ≥1.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- fir_en, in, 1: global enable. Low freezes all state.
- in_valid, in, 1: sample valid.
- in_ready, out, 1: block can accept a sample.
- in_ch, in, CH_W: channel of the sample. CH_W = max(1, $clog2(N_CH)).
- in_wave, in, BIT_PREC: signed sample.
- coef_we, in, 1: coefficient write strobe.
- coef_addr, in, TAP_W: tap index. TAP_W = $clog2(N_TAPS).
- coef_data, in, COEF_W: signed coefficient value.
- coef_ready, out, 1: coefficient writes are currently honoured.
- out_valid, out, 1: one-cycle result pulse.
- out_ch, out, CH_W: channel of the result.
- out_wave, out, OUT_SIZE: signed full-precision result. OUT_SIZE = BIT_PREC+COEF_W+TAP_W.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE; tap counter and accumulator = 0.
  - All delay lines = 0.
  - Coefficients = identity: c[0] = 1, all others = 0.
  - out_valid = 0, out_ch = 0, out_wave = 0.
  - in_ready and coef_ready follow IDLE decoding.
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - in_ready = fir_en; coef_ready = fir_en.
  - A sample is accepted on a rising edge where in_valid & in_ready.
  - On accept, the delay line of in_ch shifts: x[ch][k] ← x[ch][k-1], x[ch][0] ← in_wave.
  - The channel is latched; tap counter = 0, acc = 0; next state MAC.
  - If in_ch ≥ N_CH: sample is consumed and dropped, no shift, no output, FSM stays in IDLE.
- MAC:
  - Each enabled cycle: acc ← acc + x[ch][k]*c[k] (signed); k ← k+1.
  - After N_TAPS enabled cycles (k = N_TAPS-1 processed), go to DONE.
  - in_ready = 0, coef_ready = 0.
- DONE:
  - out_wave ← acc, out_ch ← latched channel, out_valid = 1 for exactly one cycle.
  - Next state IDLE.
  - out_wave/out_ch hold their value until the next DONE.
- Latency: a sample accepted at edge t gives out_valid high in the cycle after edge t+N_TAPS+1, with all enabled. Throughput is one sample per N_TAPS+2 cycles.
- fir_en low:
  - FSM, counter, accumulator, delay lines and coefficients hold.
  - in_ready = 0, coef_ready = 0, out_valid = 0.
  - A DONE pulse is deferred until fir_en returns high. It is never lost or duplicated.
- Coefficient write:
  - Honoured only when coef_we & coef_ready; otherwise silently dropped.
  - A write in the same cycle as a sample accept takes effect before the first MAC cycle.
  - coef_addr ≥ N_TAPS: write dropped.
- Arithmetic:
  - Two's complement throughout. Product width = BIT_PREC+COEF_W.
  - Accumulator width = OUT_SIZE. Overflow is impossible by construction; no saturation or rounding.
- Reset mid-operation: the calculation in flight is abandoned, no out_valid is issued, and all history is cleared.
- There is no output backpressure. The consumer must accept every out_valid pulse.

Decomposition:
- fir_pkg (extend the existing package) holds:
  - Default constants: BIT_PREC, COEF_W, N_TAPS, N_CH.
  - Derived widths: TAP_W, CH_W, OUT_SIZE.
  - typedef enum fir_state_t {IDLE, MAC, DONE}.
- Sub-module fir_mac:
  - Signed multiply-accumulate with synchronous clear and enable, parametrised by the three widths.
- fir_tdm instantiates fir_mac and holds the FSM, the delay-line array and the coefficient register file.

Test Plan:
- Reset defaults: after reset, in_ready = 1, out_valid = 0. Drive ch0 sample 5 → out_wave = 5, out_ch = 0, out_valid exactly N_TAPS+2 cycles after accept (identity coefficients).
- Moving sum: load all 8 coefficients = 1; drive ch0 step of value 1 for 10 samples → outputs 1,2,3,4,5,6,7,8,8,8.
- Channel isolation: coefficients all 1; interleave ch0 = 1 and ch1 = 10 → ch0 outputs 1,2,3…; ch1 outputs 10,20,30…; neither history disturbs the other.
- Extremes and stall:
  - Coefficients all -128, inputs all -128 for 8 samples on ch1 → final out_wave = +131072 with no wrap.
  - Drop fir_en for 3 cycles mid-MAC → same result, latency +3, exactly one out_valid pulse.
- Coefficient protection: coef_we to tap 0 = 2 during MAC → coef_ready = 0, write ignored, the current and next outputs use the old c[0]. The same write in IDLE → next output doubles.
- Reset and illegal channel:
  - Assert rst_n low mid-MAC → no out_valid; after release, sample 3 → output 3 (history cleared, identity coefficients).
  - With N_CH = 3, in_ch = 3 → accepted, no output, channel 0–2 histories unchanged.
